// File: rtl/alu_8bit_pkg.sv
// Shared constants for the 8-bit ALU: opcode encodings, datapath widths and
// the multiplier sequencer states.
package alu8_pkg;

    localparam int OPND_W  = 8;
    localparam int RES_W   = 16;
    localparam int INSTR_W = 18;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DONE  = 2'b10,
        ST_WRITE = 2'b11
    } mul_state_e;

endpackage

// File: rtl/alu_8bit_if.sv
// Instruction/result bus between the issuing stage and the ALU.
import alu8_pkg::*;

interface alu_8bit_if;
    logic [INSTR_W-1:0] instr;
    logic               check;
    logic [RES_W-1:0]   Y;
    logic               overflow;
    logic               Cout;

    modport master (output instr, output check, input Y, input overflow, input Cout);
    modport slave  (input instr, input check, output Y, output overflow, output Cout);
endinterface

// File: rtl/alu_8bit_seq_mult8.sv
// Unsigned 8x8 shift-add multiplier: one partial product per cycle, LSB of
// the multiplier first, then a DONE and a WRITE cycle before returning idle.
import alu8_pkg::*;

module seq_mult8 (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                start,
    input  logic [OPND_W-1:0]   a,
    input  logic [OPND_W-1:0]   b,
    output logic                busy,
    output logic                done,
    output logic [RES_W-1:0]    product
);

    mul_state_e          state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [RES_W-1:0]    mcand_q, mcand_d;
    logic [OPND_W-1:0]   mplier_q, mplier_d;
    logic [RES_W-1:0]    acc_q, acc_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = {8'h00, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Multiplicand walks left while the multiplier walks right,
                // so bit 0 of mplier_q always selects the current partial product.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_WRITE);
    assign product = acc_q;

endmodule

// File: rtl/alu_8bit.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND into registered outputs, plus a
// sequential multiply whose product lands in the same output registers.
import alu8_pkg::*;

module alu_8bit (
    input  logic        clock,
    input  logic        rst_n,
    alu_8bit_if.slave   bus
);

    logic [1:0]        opcode;
    logic [OPND_W-1:0] opa, opb;
    logic [OPND_W:0]   sum9, diff9;

    logic              mul_start, mul_busy, mul_done;
    logic [RES_W-1:0]  mul_product;

    logic [RES_W-1:0]  y_q, y_d;
    logic              ovf_q, ovf_d;
    logic              cout_q, cout_d;

    assign opcode = bus.instr[17:16];
    assign opa    = bus.instr[15:8];
    assign opb    = bus.instr[7:0];

    assign sum9  = {1'b0, opa} + {1'b0, opb};
    assign diff9 = {1'b0, opa} + {1'b0, ~opb} + 9'd1;

    seq_mult8 u_mult (
        .clock   (clock),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (opa),
        .b       (opb),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        y_d       = y_q;
        ovf_d     = ovf_q;
        cout_d    = cout_q;
        mul_start = 1'b0;
        // The write cycle is part of busy, so it must win before decode.
        if (mul_done) begin
            y_d    = mul_product;
            ovf_d  = 1'b0;
            cout_d = 1'b0;
        end else if (!mul_busy) begin
            case (opcode)
                OP_ADD: begin
                    y_d    = {8'h00, sum9[7:0]};
                    cout_d = sum9[8];
                    ovf_d  = (opa[7] == opb[7]) && (sum9[7] != opa[7]);
                end
                OP_SUB: begin
                    y_d    = {8'h00, diff9[7:0]};
                    cout_d = diff9[8];
                    ovf_d  = (opa[7] != opb[7]) && (diff9[7] != opa[7]);
                end
                OP_AND: begin
                    y_d    = {8'h00, opa & opb};
                    cout_d = 1'b0;
                    ovf_d  = 1'b0;
                end
                default: begin
                    mul_start = bus.check;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            y_q    <= '0;
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            ovf_q  <= ovf_d;
            cout_q <= cout_d;
        end
    end

    assign bus.Y        = y_q;
    assign bus.overflow = ovf_q;
    assign bus.Cout     = cout_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Directed bench for alu_8bit: hand-computed vectors for ADD/SUB/AND, multiply
// latency and hold behaviour, and reset in the middle of a multiply.
import alu8_pkg::*;

module tb_alu_8bit;

    logic clock = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_8bit_if bus ();

    alu_8bit dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] y, input logic ov, input logic co);
        chk({tag, ".Y"}, bus.Y, y);
        chk({tag, ".overflow"}, {15'h0, bus.overflow}, {15'h0, ov});
        chk({tag, ".Cout"}, {15'h0, bus.Cout}, {15'h0, co});
    endtask

    task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic chk_bit);
        @(negedge clock);
        bus.instr = {op, a, b};
        bus.check = chk_bit;
        $display("drive op=%b A=%h B=%h check=%b", op, a, b, chk_bit);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.instr = '0;
        bus.check = 1'b0;
        #2 rst_n = 1'b0;
        step();
        step();
        chk_out("reset", 16'h0000, 1'b0, 1'b0);

        @(negedge clock);
        rst_n = 1'b1;

        drive(OP_ADD, 8'hA8, 8'hAA, 1'b0); step();
        chk_out("add_a8_aa", 16'h0052, 1'b1, 1'b1);

        drive(OP_SUB, 8'h2A, 8'h29, 1'b0); step();
        chk_out("sub_2a_29", 16'h0001, 1'b0, 1'b1);

        drive(OP_SUB, 8'h00, 8'h01, 1'b0); step();
        chk_out("sub_00_01", 16'h00FF, 1'b0, 1'b0);

        drive(OP_AND, 8'hE9, 8'h22, 1'b0); step();
        chk_out("and_e9_22", 16'h0020, 1'b0, 1'b0);

        drive(OP_ADD, 8'h7F, 8'h01, 1'b0); step();
        chk_out("add_7f_01", 16'h0080, 1'b1, 1'b0);

        drive(OP_MUL, 8'h05, 8'h06, 1'b0); step();
        chk_out("mul_nocheck_hold", 16'h0080, 1'b1, 1'b0);
        step();
        chk_out("mul_nocheck_hold2", 16'h0080, 1'b1, 1'b0);

        // 8*8: load edge, nine holding edges, product on the tenth
        drive(OP_MUL, 8'h08, 8'h08, 1'b1); step();
        chk_out("mul8_load", 16'h0080, 1'b1, 1'b0);
        drive(OP_ADD, 8'h01, 8'h01, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step();
            chk_out($sformatf("mul8_hold_L+%0d", i), 16'h0080, 1'b1, 1'b0);
        end
        step();
        chk_out("mul8_result_L+10", 16'h0040, 1'b0, 1'b0);

        // 0x11*0x11 with a stray check pulse and an ADD during BUSY
        drive(OP_MUL, 8'h11, 8'h11, 1'b1); step();
        drive(OP_MUL, 8'h11, 8'h11, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            if (i == 2) drive(OP_MUL, 8'hFF, 8'hFF, 1'b1);
            if (i == 3) drive(OP_ADD, 8'h7F, 8'h01, 1'b0);
            step();
            chk_out($sformatf("mul11_hold_L+%0d", i), 16'h0040, 1'b0, 1'b0);
        end
        step();
        chk_out("mul11_result", 16'h0121, 1'b0, 1'b0);

        // back-to-back: accepted on the first edge after returning to IDLE
        drive(OP_MUL, 8'hFF, 8'hFF, 1'b1); step();
        drive(OP_MUL, 8'hFF, 8'hFF, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step();
            chk_out($sformatf("mulff_hold_L+%0d", i), 16'h0121, 1'b0, 1'b0);
        end
        step();
        chk_out("mulff_result", 16'hFE01, 1'b0, 1'b0);

        drive(OP_ADD, 8'h7F, 8'h01, 1'b0); step();
        chk_out("add_before_abort", 16'h0080, 1'b1, 1'b0);

        // reset asserted at edge L+4 of a multiply
        drive(OP_MUL, 8'h03, 8'h05, 1'b1); step();
        drive(OP_MUL, 8'h03, 8'h05, 1'b0);
        for (int i = 1; i <= 4; i++) step();
        chk_out("abort_pre_reset", 16'h0080, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("abort_reset", 16'h0000, 1'b0, 1'b0);

        @(negedge clock);
        rst_n     = 1'b1;
        bus.instr = {OP_ADD, 8'h10, 8'h20};
        bus.check = 1'b0;
        $display("release reset, drive op=00 A=10 B=20 check=0");
        step();
        chk_out("add_after_reset", 16'h0030, 1'b0, 1'b0);

        drive(OP_MUL, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 11; i++) step();
        chk_out("no_stale_product", 16'h0030, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
